// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with burst lock, pipelined address/data ownership
// and muxing of the owners' control and write data onto the shared bus segment.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HREADY,
  input  logic [NUM_MASTERS-1:0]        m_hbusreq,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [2*NUM_MASTERS-1:0]      m_htrans,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]        m_hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic [ADDR_W-1:0]             HADDR,
  output logic                          HWRITE,
  output logic [1:0]                    HTRANS,
  output logic [DATA_W-1:0]             HWDATA
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_OWN} state_t;

  state_t                 r_state, w_state_next;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
  logic [PTR_W-1:0]       r_hmaster, w_hmaster_next;
  logic                   r_addr_valid, w_addr_valid_next;
  logic [PTR_W-1:0]       r_data_owner, w_data_owner_next;
  logic                   r_data_valid, w_data_valid_next;
  logic [CNT_W-1:0]       r_beat_cnt, w_beat_cnt_next;
  logic [PTR_W-1:0]       r_rr_ptr, w_rr_ptr_next;

  logic [ADDR_W-1:0] w_addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] w_wdata_arr [NUM_MASTERS];
  logic [1:0]        w_trans_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = m_haddr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = m_hwdata[gi*DATA_W +: DATA_W];
      assign w_trans_arr[gi] = m_htrans[2*gi +: 2];
    end
  endgenerate

  logic                   w_rr_found;
  logic [PTR_W-1:0]       w_rr_winner;
  logic [PTR_W-1:0]       w_cand;
  logic                   w_owner_req;
  logic [1:0]             w_owner_trans;
  logic [NUM_MASTERS-1:0] w_owner_onehot;
  logic                   w_other_req;
  logic                   w_rearb;

  // First requester found walking upward from the master after rr_ptr.
  always_comb begin
    w_rr_found  = 1'b0;
    w_rr_winner = r_rr_ptr;
    w_cand      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + i) % NUM_MASTERS);
      if (!w_rr_found && m_hbusreq[w_cand]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = w_cand;
      end
    end
  end

  assign w_owner_req    = m_hbusreq[r_hmaster];
  assign w_owner_trans  = w_trans_arr[r_hmaster];
  assign w_owner_onehot = NUM_MASTERS'(1) << r_hmaster;
  assign w_other_req    = |(m_hbusreq & ~w_owner_onehot);
  // IDLE and NONSEQ both have bit 0 clear: only those are burst boundaries.
  assign w_rearb = !w_owner_trans[0] &&
                   (!w_owner_req || (r_beat_cnt >= BEAT_MAX && w_other_req));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_hmaster    <= '0;
      r_addr_valid <= 1'b0;
      r_data_owner <= '0;
      r_data_valid <= 1'b0;
      r_beat_cnt   <= '0;
      r_rr_ptr     <= PTR_W'(NUM_MASTERS - 1);
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_hmaster    <= w_hmaster_next;
      r_addr_valid <= w_addr_valid_next;
      r_data_owner <= w_data_owner_next;
      r_data_valid <= w_data_valid_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_rr_ptr     <= w_rr_ptr_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_hmaster_next    = r_hmaster;
    w_addr_valid_next = r_addr_valid;
    w_data_owner_next = r_data_owner;
    w_data_valid_next = r_data_valid;
    w_beat_cnt_next   = r_beat_cnt;
    w_rr_ptr_next     = r_rr_ptr;
    if (HREADY) begin
      w_data_owner_next = r_hmaster;
      w_data_valid_next = r_addr_valid;
      if (HTRANS[1] && r_beat_cnt < BEAT_MAX) begin
        w_beat_cnt_next = r_beat_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rr_found) begin
            w_grant_next  = NUM_MASTERS'(1) << w_rr_winner;
            w_rr_ptr_next = w_rr_winner;
            w_state_next  = S_GRANT;
          end
        end
        S_GRANT: begin
          // rr_ptr always equals the index of the master holding the grant.
          w_hmaster_next    = r_rr_ptr;
          w_addr_valid_next = 1'b1;
          w_state_next      = S_OWN;
          if (r_rr_ptr != r_hmaster) begin
            w_beat_cnt_next = '0;
          end
        end
        S_OWN: begin
          if (w_rearb) begin
            if (w_rr_found) begin
              w_grant_next  = NUM_MASTERS'(1) << w_rr_winner;
              w_rr_ptr_next = w_rr_winner;
              w_state_next  = S_GRANT;
            end else begin
              w_grant_next      = '0;
              w_addr_valid_next = 1'b0;
              w_state_next      = S_IDLE;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign m_hgrant = r_grant;
  assign HMASTER  = r_hmaster;
  assign HADDR    = r_addr_valid ? w_addr_arr[r_hmaster] : '0;
  assign HWRITE   = r_addr_valid ? m_hwrite[r_hmaster] : 1'b0;
  assign HTRANS   = r_addr_valid ? w_trans_arr[r_hmaster] : 2'b00;
  assign HWDATA   = r_data_valid ? w_wdata_arr[r_data_owner] : '0;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: vector table, directed corner sequences
// and randomized traffic compared against an integer-level ownership model.
module tb_ahb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            HCLK, HRESET, HREADY;
  logic [N-1:0]    m_hbusreq;
  logic [N*AW-1:0] m_haddr;
  logic [N-1:0]    m_hwrite;
  logic [2*N-1:0]  m_htrans;
  logic [N*DW-1:0] m_hwdata;
  logic [N-1:0]    m_hgrant;
  logic [1:0]      HMASTER;
  logic [AW-1:0]   HADDR;
  logic            HWRITE;
  logic [1:0]      HTRANS;
  logic [DW-1:0]   HWDATA;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HREADY(HREADY),
    .m_hbusreq(m_hbusreq), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
    .m_htrans(m_htrans), .m_hwdata(m_hwdata), .m_hgrant(m_hgrant),
    .HMASTER(HMASTER), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, who owns the address and data phases.
  int md_grant, md_addr, md_data, md_hmaster, md_ptr, md_beats;
  bit md_pending;

  function automatic void model_reset();
    md_grant = -1; md_pending = 0; md_addr = -1; md_data = -1;
    md_hmaster = 0; md_ptr = N - 1; md_beats = 0;
  endfunction

  function automatic void model_update();
    int tr, old_beats, w;
    bit may_decide, others;
    tr = (md_addr >= 0) ? int'(m_htrans[2*md_addr +: 2]) : 0;
    old_beats = md_beats;
    md_data = md_addr;
    if (tr >= 2 && md_beats < MB) md_beats++;
    if (md_pending) begin
      if (md_grant != md_hmaster) md_beats = 0;
      md_hmaster = md_grant;
      md_addr = md_grant;
      md_pending = 0;
    end else begin
      if (md_grant < 0) may_decide = 1;
      else begin
        others = 0;
        for (int k = 0; k < N; k++) if (k != md_addr && m_hbusreq[k]) others = 1;
        may_decide = (tr == 0 || tr == 2) &&
                     (!m_hbusreq[md_addr] || (old_beats >= MB && others));
      end
      if (may_decide) begin
        w = -1;
        for (int d = 1; d <= N; d++)
          if (w < 0 && m_hbusreq[(md_ptr + d) % N]) w = (md_ptr + d) % N;
        if (w >= 0) begin
          md_grant = w; md_ptr = w; md_pending = 1;
        end else begin
          md_grant = -1; md_addr = -1;
        end
      end
    end
  endfunction

  task automatic model_check();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic [1:0]    et;
    ea = '0; ed = '0; ew = 1'b0; et = 2'b00;
    if (md_addr >= 0) begin
      ea = m_haddr[md_addr*AW +: AW];
      ew = m_hwrite[md_addr];
      et = m_htrans[2*md_addr +: 2];
    end
    if (md_data >= 0) ed = m_hwdata[md_data*DW +: DW];
    chk("m_grant", m_hgrant, (md_grant < 0) ? 0 : (1 << md_grant));
    chk("m_hmaster", HMASTER, md_hmaster);
    chk("m_haddr", HADDR, ea);
    chk("m_hwrite", HWRITE, ew);
    chk("m_htrans", HTRANS, et);
    chk("m_hwdata", HWDATA, ed);
    chk("grant_onehot", ($countones(m_hgrant) <= 1), 1);
  endtask

  task automatic pre();
    #1;
    model_check();
  endtask

  task automatic post();
    @(posedge HCLK);
    if (HREADY && !HRESET) model_update();
    @(negedge HCLK);
  endtask

  task automatic set_trans(input int k, input logic [1:0] t);
    m_htrans[2*k +: 2] = t;
  endtask

  task automatic reset_all();
    HRESET = 1'b1; m_hbusreq = '0; m_htrans = '0; HREADY = 1'b1;
    #2;
    HRESET = 1'b0;
    model_reset();
    @(negedge HCLK);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] tr1;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] hm;
    logic [1:0] tr;
    logic [7:0] wd;
  } vec_t;
  vec_t vt [7];

  initial begin
    vt[0] = '{4'b0010, 2'b00, 1'b1, 4'b0000, 2'd0, 2'b00, 8'h00};
    vt[1] = '{4'b0010, 2'b10, 1'b1, 4'b0010, 2'd0, 2'b00, 8'h00};
    vt[2] = '{4'b0010, 2'b10, 1'b1, 4'b0010, 2'd1, 2'b10, 8'h00};
    vt[3] = '{4'b0010, 2'b11, 1'b1, 4'b0010, 2'd1, 2'b11, 8'hA1};
    vt[4] = '{4'b0000, 2'b00, 1'b1, 4'b0010, 2'd1, 2'b00, 8'hA1};
    vt[5] = '{4'b0000, 2'b00, 1'b1, 4'b0000, 2'd1, 2'b00, 8'hA1};
    vt[6] = '{4'b0000, 2'b00, 1'b1, 4'b0000, 2'd1, 2'b00, 8'h00};

    HRESET = 1'b1; HREADY = 1'b1; m_hbusreq = '0; m_htrans = '0;
    for (int k = 0; k < N; k++) begin
      m_haddr[k*AW +: AW]  = AW'(21'h10000 + k * 21'h1111);
      m_hwdata[k*DW +: DW] = DW'(8'hA0 + k);
      m_hwrite[k]          = k[0];
    end
    model_reset();
    @(negedge HCLK);
    pre();
    chk("rst_grant", m_hgrant, 0);
    chk("rst_hmaster", HMASTER, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    HRESET = 1'b0;
    post();

    // Single master 1 transfer from reset.
    reset_all();
    for (int i = 0; i < 7; i++) begin
      m_hbusreq = vt[i].req; set_trans(1, vt[i].tr1); HREADY = vt[i].rdy;
      pre();
      chk($sformatf("vec%0d_grant", i), m_hgrant, vt[i].g);
      chk($sformatf("vec%0d_hmaster", i), HMASTER, vt[i].hm);
      chk($sformatf("vec%0d_htrans", i), HTRANS, vt[i].tr);
      chk($sformatf("vec%0d_hwdata", i), HWDATA, vt[i].wd);
      post();
    end

    // All four request, single NONSEQ each, then drop: grants in order 0,1,2,3,0.
    reset_all();
    m_hbusreq = 4'b1111;
    pre(); post();
    for (int n = 0; n < 5; n++) begin
      pre(); chk("rr_order", m_hgrant, 1 << (n % 4)); post();
      set_trans(n % 4, 2'b10);
      pre(); post();
      set_trans(n % 4, 2'b00);
      m_hbusreq[n % 4] = 1'b0;
      pre(); post();
      m_hbusreq[n % 4] = 1'b1;
    end

    // Burst lock beyond MAX_BURST, preemption at the next boundary.
    reset_all();
    m_hbusreq = 4'b0001;
    pre(); post(); pre(); post();
    m_hbusreq = 4'b0101; set_trans(0, 2'b10); set_trans(2, 2'b10);
    pre(); chk("lock_grant", m_hgrant, 4'b0001); chk("lock_hmaster", HMASTER, 0); post();
    set_trans(0, 2'b11);
    for (int b = 0; b < 7; b++) begin
      pre(); chk("lock_grant", m_hgrant, 4'b0001); chk("lock_hmaster", HMASTER, 0); post();
    end
    set_trans(0, 2'b00);
    pre(); chk("lock_end_grant", m_hgrant, 4'b0001); post();
    pre(); chk("preempt_grant", m_hgrant, 4'b0100); chk("preempt_old_owner", HMASTER, 0); post();
    pre(); chk("preempt_hmaster", HMASTER, 2); chk("preempt_htrans", HTRANS, 2'b10); post();

    // HREADY stall during an m1 write with m3 waiting.
    reset_all();
    m_hbusreq = 4'b0010;
    pre(); post(); pre(); post();
    set_trans(1, 2'b10);
    pre(); post();
    set_trans(1, 2'b00); m_hbusreq = 4'b1000; HREADY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pre();
      chk("stall_grant", m_hgrant, 4'b0010);
      chk("stall_hmaster", HMASTER, 1);
      chk("stall_hwdata", HWDATA, 8'hA1);
      post();
    end
    HREADY = 1'b1;
    pre(); chk("resume_grant_hold", m_hgrant, 4'b0010); post();
    pre(); chk("resume_grant", m_hgrant, 4'b1000); chk("resume_old_owner", HMASTER, 1); post();
    pre(); chk("resume_hmaster", HMASTER, 3); post();

    // Asynchronous reset mid-burst, then master 0 beats master 3.
    reset_all();
    m_hbusreq = 4'b0001;
    pre(); post(); pre(); post();
    set_trans(0, 2'b10); pre(); post();
    set_trans(0, 2'b11); pre(); post();
    m_hbusreq = 4'b1001;
    #2 HRESET = 1'b1;
    #1;
    chk("areset_grant", m_hgrant, 0);
    chk("areset_htrans", HTRANS, 2'b00);
    chk("areset_haddr", HADDR, 0);
    #1 HRESET = 1'b0;
    model_reset();
    m_htrans = '0;
    post();
    pre(); chk("after_reset_winner", m_hgrant, 4'b0001); post();

    // Quiet bus.
    reset_all();
    for (int q = 0; q < 10; q++) begin
      pre();
      chk("quiet_grant", m_hgrant, 0);
      chk("quiet_haddr", HADDR, 0);
      chk("quiet_htrans", HTRANS, 0);
      post();
    end

    // Randomized traffic against the model.
    reset_all();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) m_hbusreq[k] = ~m_hbusreq[k];
        if ($urandom_range(0, 2) == 0) set_trans(k, 2'($urandom_range(0, 3)));
      end
      m_haddr  = {$urandom, $urandom, $urandom};
      m_hwdata = $urandom;
      m_hwrite = 4'($urandom);
      HREADY   = ($urandom_range(0, 3) != 0);
      pre();
      post();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
